core_if_prefetch: RTL and testbench

Parametrised instruction-fetch front end with a configurable number of outstanding bus reads and a configurable instruction-queue depth. It realigns 16/32-bit (RVC) instructions across word boundaries and discards stale in-flight responses after a redirect. It sits between the Avalon-style instruction bus master and the decode stage, and replaces the fixed two-deep fetch path.

---
 rtl/core_if_prefetch.sv | 167 ++++++++++++++++
 tb/tb_core_if_prefetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/core_if_prefetch.sv
// core_if_prefetch: instruction fetch front end with bounded outstanding reads,
// RVC realignment across word boundaries and stale-response discard after redirect.
module core_if_prefetch #(
    parameter logic [31:0] REST_ADDR       = 32'd0,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          ISTR_FIFO_DEPTH = 4,
    parameter bit          RVC_EN          = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        avl_m0_read,
    output logic [31:0] avl_m0_address,
    input  logic        avl_m0_request_ready,
    input  logic [31:0] avl_m0_read_data,
    input  logic        avl_m0_read_data_valid,
    output logic        avl_m0_write,
    output logic [31:0] avl_m0_write_data,
    output logic [3:0]  avl_m0_byte_en,
    output logic        avl_m0_begin_burst_transfer,
    output logic [7:0]  avl_m0_burst_count,
    input  logic        redirect_en,
    input  logic [31:0] redirect_addr,
    input  logic        ctr_stop,
    output logic [31:0] fd_istr,
    output logic [31:0] fd_pc,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic        busy
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int RD = 2 ** CW;
    localparam int IW = $clog2(ISTR_FIFO_DEPTH);
    localparam logic [CW:0] MAXV = (CW + 1)'(MAX_OUTSTANDING);

    logic          run, req_pending, stale;
    logic [31:0]   fetch_addr, held_addr, pc, pc_n, word, e_istr;
    logic [CW-1:0] in_flight, in_flight_n, discard_cnt, rcnt;
    logic [31:0]   rmem [RD];
    logic [31:0]   imem_istr [ISTR_FIFO_DEPTH];
    logic [31:0]   imem_pc [ISTR_FIFO_DEPTH];
    logic [IW-1:0] wp, rp;
    logic [IW:0]   icnt;
    logic          hw_valid, hw_valid_n, skip_lo, skip_n;
    logic [15:0]   hw_data, hw_data_n;
    logic          accept, drop, push, pop, emit, start, avail, align_en, ipop;

    assign avl_m0_write                = 1'b0;
    assign avl_m0_write_data           = '0;
    assign avl_m0_byte_en              = 4'hf;
    assign avl_m0_begin_burst_transfer = 1'b0;
    assign avl_m0_burst_count          = '0;

    assign avail    = rcnt != '0;
    assign word     = rmem[0];
    assign align_en = !icnt[IW] && !ctr_stop && !redirect_en;
    assign fd_valid = icnt != '0;
    assign ipop     = fd_valid && fd_ready;
    assign fd_istr  = fd_valid ? imem_istr[rp] : '0;
    assign fd_pc    = fd_valid ? imem_pc[rp] : '0;
    assign busy     = in_flight != '0;

    // Budget counts this cycle's aligner pop so a full stream needs no bubble.
    assign start = run && !req_pending && !ctr_stop && !redirect_en &&
                   ({1'b0, in_flight} + {1'b0, rcnt} - {{CW{1'b0}}, pop}) < MAXV;
    assign avl_m0_read    = req_pending || start;
    assign avl_m0_address = req_pending ? held_addr : fetch_addr;
    assign accept         = avl_m0_read && avl_m0_request_ready;
    assign drop           = avl_m0_read_data_valid && discard_cnt != '0;
    assign push           = avl_m0_read_data_valid && !drop && !redirect_en;
    assign in_flight_n    = in_flight + CW'(accept) - CW'(avl_m0_read_data_valid);

    always_comb begin
        pop        = 1'b0;
        emit       = 1'b0;
        e_istr     = word;
        pc_n       = pc;
        hw_data_n  = hw_data;
        hw_valid_n = hw_valid;
        skip_n     = skip_lo;
        if (align_en) begin
            if (skip_lo) begin
                if (avail) begin
                    pop        = 1'b1;
                    hw_data_n  = word[31:16];
                    hw_valid_n = 1'b1;
                    skip_n     = 1'b0;
                end
            end else if (hw_valid && RVC_EN && hw_data[1:0] != 2'b11) begin
                emit       = 1'b1;
                e_istr     = {16'd0, hw_data};
                pc_n       = pc + 32'd2;
                hw_valid_n = 1'b0;
            end else if (hw_valid) begin
                if (avail) begin
                    emit      = 1'b1;
                    pop       = 1'b1;
                    e_istr    = {word[15:0], hw_data};
                    hw_data_n = word[31:16];
                    pc_n      = pc + 32'd4;
                end
            end else if (avail) begin
                emit = 1'b1;
                pop  = 1'b1;
                if (RVC_EN && word[1:0] != 2'b11) begin
                    e_istr     = {16'd0, word[15:0]};
                    hw_data_n  = word[31:16];
                    hw_valid_n = 1'b1;
                    pc_n       = pc + 32'd2;
                end else begin
                    pc_n = pc + 32'd4;
                end
            end
        end
        if (redirect_en) begin
            pc_n       = redirect_addr & (RVC_EN ? ~32'd1 : ~32'd3);
            hw_valid_n = 1'b0;
            skip_n     = RVC_EN && redirect_addr[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            req_pending <= 1'b0;
            stale       <= 1'b0;
            held_addr   <= REST_ADDR & ~32'd3;
            fetch_addr  <= REST_ADDR & ~32'd3;
            pc          <= REST_ADDR;
            in_flight   <= '0;
            discard_cnt <= '0;
            rcnt        <= '0;
            hw_valid    <= 1'b0;
            hw_data     <= '0;
            skip_lo     <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            icnt        <= '0;
        end else begin
            run         <= 1'b1;
            req_pending <= avl_m0_read && !avl_m0_request_ready;
            if (start) held_addr <= fetch_addr;
            fetch_addr  <= redirect_en ? redirect_addr & ~32'd3 : start ? fetch_addr + 32'd4 : fetch_addr;
            in_flight   <= in_flight_n;
            // A request still held on the bus at redirect returns stale data once accepted.
            stale       <= redirect_en ? req_pending && !avl_m0_request_ready : stale && !accept;
            discard_cnt <= redirect_en ? in_flight_n : discard_cnt - CW'(drop) + CW'(accept && stale);
            rcnt        <= redirect_en ? '0 : rcnt + CW'(push) - CW'(pop);
            pc          <= pc_n;
            hw_valid    <= hw_valid_n;
            hw_data     <= hw_data_n;
            skip_lo     <= skip_n;
            wp          <= redirect_en ? '0 : wp + IW'(emit);
            rp          <= redirect_en ? '0 : rp + IW'(ipop);
            icnt        <= redirect_en ? '0 : icnt + (IW + 1)'(emit) - (IW + 1)'(ipop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RD - 1; i++)
            if (pop) rmem[i] <= rmem[i + 1];
        if (push) rmem[rcnt - CW'(pop)] <= avl_m0_read_data;
        if (emit) begin
            imem_istr[wp] <= e_istr;
            imem_pc[wp]   <= pc;
        end
    end
endmodule

// File: tb/tb_core_if_prefetch.sv
// tb_core_if_prefetch: directed scenarios against a small in-order memory model
// with one- or two-cycle read latency.
module tb_core_if_prefetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        avl_read, avl_write, avl_bbt, rdv;
    logic [31:0] avl_address, avl_wdata, rdata;
    logic [3:0]  avl_be;
    logic [7:0]  avl_bc;
    logic        redirect_en = 1'b0, ctr_stop = 1'b0, fd_ready = 1'b0, fd_valid, busy;
    logic [31:0] redirect_addr = '0, fd_istr, fd_pc;
    logic        ready = 1'b1, lat2 = 1'b0;
    logic        p1_v, p2_v;
    logic [31:0] p1_d, p2_d;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] q_pc[$], q_istr[$], q_addr[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    core_if_prefetch dut (
        .clk(clk), .rst_n(rst_n),
        .avl_m0_read(avl_read), .avl_m0_address(avl_address), .avl_m0_request_ready(ready),
        .avl_m0_read_data(rdata), .avl_m0_read_data_valid(rdv),
        .avl_m0_write(avl_write), .avl_m0_write_data(avl_wdata), .avl_m0_byte_en(avl_be),
        .avl_m0_begin_burst_transfer(avl_bbt), .avl_m0_burst_count(avl_bc),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr), .ctr_stop(ctr_stop),
        .fd_istr(fd_istr), .fd_pc(fd_pc), .fd_valid(fd_valid), .fd_ready(fd_ready), .busy(busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0013;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
        end else begin
            p1_v <= avl_read && ready;
            p1_d <= mem_word(avl_address);
            p2_v <= p1_v;
            p2_d <= p1_d;
        end
    end
    assign rdv   = lat2 ? p2_v : p1_v;
    assign rdata = lat2 ? p2_d : p1_d;

    always @(posedge clk) begin
        if (rst_n) begin
            if (fd_valid && fd_ready) begin
                q_pc.push_back(fd_pc);
                q_istr.push_back(fd_istr);
            end
            if (avl_read && ready) q_addr.push_back(avl_address);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic l2, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0; ready = rdy; lat2 = l2; fd_ready = 1'b0; ctr_stop = 1'b0;
        redirect_en = 1'b0; redirect_addr = '0;
        mem.delete();
        tick(2);
        q_pc.delete(); q_istr.delete(); q_addr.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        checks++; if (avl_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", avl_read); end
        checks++; if (avl_address !== 32'h0) begin errors++; $display("FAIL reset_address got %h want 0", avl_address); end
        checks++; if (fd_valid !== 1'b0) begin errors++; $display("FAIL reset_fd_valid got %b want 0", fd_valid); end
        checks++; if (fd_istr !== 32'h0 || fd_pc !== 32'h0) begin errors++; $display("FAIL reset_fd got istr %h pc %h want 0 0", fd_istr, fd_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (avl_write !== 1'b0 || avl_be !== 4'hf || avl_bc !== 8'h0 || avl_bbt !== 1'b0) begin errors++; $display("FAIL reset_ties got wr %b be %h bc %h bbt %b", avl_write, avl_be, avl_bc, avl_bbt); end
        rst_n = 1'b1;
        #1;
        checks++; if (avl_read !== 1'b0) begin errors++; $display("FAIL release_read got %b want 0", avl_read); end
        @(negedge clk);
        checks++; if (avl_read !== 1'b1 || avl_address !== 32'h0) begin errors++; $display("FAIL first_read got %b @%h want 1 @0", avl_read, avl_address); end
    endtask

    task automatic test_stream;
        int first = 0;
        do_reset(1'b0, 1'b1);
        fd_ready = 1'b1;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            @(negedge clk);
            if (fd_valid) first = i;
        end
        checks++; if (first != 4) begin errors++; $display("FAIL stream_latency got %0d want 4", first); end
        checks++; if (fd_pc !== 32'h0 || fd_istr !== 32'h13) begin errors++; $display("FAIL stream_first got pc %h istr %h want 0 13", fd_pc, fd_istr); end
        tick(10);
        checks++; if (q_pc.size() != 10) begin errors++; $display("FAIL stream_rate got %0d items want 10", q_pc.size()); end
        for (int i = 0; i < q_pc.size(); i++) begin
            checks++; if (q_pc[i] !== 32'(4 * i) || q_istr[i] !== 32'h13) begin errors++; $display("FAIL stream_item%0d got pc %h istr %h want %h 13", i, q_pc[i], q_istr[i], 4 * i); end
        end
        for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr%0d got %h want %h", i, q_addr[i], 4 * i); end
        end
    endtask

    task automatic test_rvc_mix;
        logic [31:0] ep [4] = '{32'h0, 32'h2, 32'h4, 32'h8};
        logic [31:0] ei [4] = '{32'h1, 32'h1, 32'h13, 32'h13};
        do_reset(1'b0, 1'b1);
        mem[32'h0] = 32'h0001_0001;
        fd_ready = 1'b1;
        tick(10);
        checks++; if (q_pc.size() < 4) begin errors++; $display("FAIL rvc_count got %0d want >=4", q_pc.size()); end
        for (int i = 0; i < 4 && i < q_pc.size(); i++) begin
            checks++; if (q_pc[i] !== ep[i] || q_istr[i] !== ei[i]) begin errors++; $display("FAIL rvc_item%0d got pc %h istr %h want %h %h", i, q_pc[i], q_istr[i], ep[i], ei[i]); end
        end
    endtask

    task automatic test_straddle;
        logic [31:0] ep [4] = '{32'h0, 32'h2, 32'h6, 32'h8};
        logic [31:0] ei [4] = '{32'h4501, 32'h13, 32'h0, 32'h13};
        do_reset(1'b0, 1'b1);
        mem[32'h0] = 32'h0013_4501;
        mem[32'h4] = 32'h0000_0000;
        fd_ready = 1'b1;
        tick(10);
        checks++; if (q_pc.size() < 4) begin errors++; $display("FAIL straddle_count got %0d want >=4", q_pc.size()); end
        for (int i = 0; i < 4 && i < q_pc.size(); i++) begin
            checks++; if (q_pc[i] !== ep[i] || q_istr[i] !== ei[i]) begin errors++; $display("FAIL straddle_item%0d got pc %h istr %h want %h %h", i, q_pc[i], q_istr[i], ep[i], ei[i]); end
        end
    endtask

    task automatic test_redirect;
        int n = 0;
        do_reset(1'b1, 1'b1);
        mem[32'h100] = 32'h0005_1234;
        fd_ready = 1'b1;
        tick(6);
        redirect_en = 1'b1; redirect_addr = 32'h102;
        @(negedge clk);
        redirect_en = 1'b0;
        q_pc.delete(); q_istr.delete(); q_addr.delete();
        tick(12);
        checks++; if (q_addr.size() < 2 || q_addr[0] !== 32'h100 || q_addr[1] !== 32'h104) begin errors++; $display("FAIL redirect_addr got %0d reads first %h want 100 104", q_addr.size(), q_addr.size() > 0 ? q_addr[0] : 32'hx); end
        checks++; if (q_pc.size() < 3) begin errors++; $display("FAIL redirect_count got %0d want >=3", q_pc.size()); end
        else begin
            checks++; if (q_pc[0] !== 32'h102 || q_istr[0] !== 32'h5) begin errors++; $display("FAIL redirect_first got pc %h istr %h want 102 5", q_pc[0], q_istr[0]); end
            checks++; if (q_pc[1] !== 32'h104 || q_istr[1] !== 32'h13) begin errors++; $display("FAIL redirect_second got pc %h istr %h want 104 13", q_pc[1], q_istr[1]); end
            checks++; if (q_pc[2] !== 32'h108 || q_istr[2] !== 32'h13) begin errors++; $display("FAIL redirect_third got pc %h istr %h want 108 13", q_pc[2], q_istr[2]); end
        end
        ctr_stop = 1'b1;
        while (busy && n < 10) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL redirect_busy got %b want 0", busy); end
        ctr_stop = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset(1'b0, 1'b1);
        tick(14);
        checks++; if (fd_valid !== 1'b1 || fd_pc !== 32'h0 || fd_istr !== 32'h13) begin errors++; $display("FAIL bp_hold got v %b pc %h istr %h want 1 0 13", fd_valid, fd_pc, fd_istr); end
        checks++; if (q_addr.size() != 6) begin errors++; $display("FAIL bp_reads got %0d want 6", q_addr.size()); end
        ctr_stop = 1'b1; fd_ready = 1'b1;
        tick(8);
        checks++; if (q_pc.size() != 4) begin errors++; $display("FAIL bp_queued got %0d want 4", q_pc.size()); end
        checks++; if (fd_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", fd_valid); end
        ctr_stop = 1'b0;
        tick(12);
        checks++; if (q_pc.size() < 10) begin errors++; $display("FAIL bp_resume got %0d want >=10", q_pc.size()); end
        for (int i = 0; i < q_pc.size(); i++) begin
            checks++; if (q_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_item%0d got pc %h want %h", i, q_pc[i], 4 * i); end
        end
    endtask

    task automatic test_hold;
        do_reset(1'b0, 1'b0);
        mem[32'h0] = 32'h0007_0007;
        fd_ready = 1'b1;
        tick(3);
        checks++; if (avl_read !== 1'b1 || avl_address !== 32'h0) begin errors++; $display("FAIL hold_wait got %b @%h want 1 @0", avl_read, avl_address); end
        ctr_stop = 1'b1;
        @(negedge clk);
        checks++; if (avl_read !== 1'b1 || avl_address !== 32'h0) begin errors++; $display("FAIL hold_stop got %b @%h want 1 @0", avl_read, avl_address); end
        redirect_en = 1'b1; redirect_addr = 32'h40;
        #1;
        checks++; if (avl_read !== 1'b1 || avl_address !== 32'h0) begin errors++; $display("FAIL hold_redirect got %b @%h want 1 @0", avl_read, avl_address); end
        @(negedge clk);
        redirect_en = 1'b0;
        tick(2);
        checks++; if (avl_read !== 1'b1 || avl_address !== 32'h0) begin errors++; $display("FAIL hold_after got %b @%h want 1 @0", avl_read, avl_address); end
        ctr_stop = 1'b0; ready = 1'b1;
        tick(12);
        checks++; if (q_addr.size() < 2 || q_addr[0] !== 32'h0 || q_addr[1] !== 32'h40) begin errors++; $display("FAIL hold_order got %0d reads second %h want 0 then 40", q_addr.size(), q_addr.size() > 1 ? q_addr[1] : 32'hx); end
        checks++; if (q_pc.size() < 2) begin errors++; $display("FAIL hold_count got %0d want >=2", q_pc.size()); end
        else begin
            checks++; if (q_pc[0] !== 32'h40 || q_istr[0] !== 32'h13) begin errors++; $display("FAIL hold_first got pc %h istr %h want 40 13", q_pc[0], q_istr[0]); end
            checks++; if (q_pc[1] !== 32'h44) begin errors++; $display("FAIL hold_second got pc %h want 44", q_pc[1]); end
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_rvc_mix;
        test_straddle;
        test_redirect;
        test_backpressure;
        test_hold;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
